fproc_meas_resp: RTL

- Responder end of the processor's function-processor (fproc) request/response handshake.
- Latches per-channel measurement results from the readout chain.
- Serves processor requests: the processor pulses fproc_enable with a channel id; the block returns the measured bit zero-extended on fproc_data, with a one-cycle fproc_ready pulse.
- Holds off the response until a fresh measurement arrives, bounded by a timeout.
- Sits between the readout/discriminator outputs and one or more proc cores; its ports map onto the proc side of fproc_iface.

---
 rtl/fproc_meas_resp.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fproc_meas_resp.sv
// Responder for the proc fproc request/response handshake: latches per-channel
// measurement bits and answers id requests, waiting for a fresh result if needed.
module fproc_meas_resp #(
  parameter int NUM_CHANNELS   = 8,
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FPROC_ID_WIDTH-1:0] fproc_id,
  input  logic                      fproc_enable,
  output logic                      fproc_ready,
  output logic [DATA_WIDTH-1:0]     fproc_data,
  input  logic [NUM_CHANNELS-1:0]   meas,
  input  logic [NUM_CHANNELS-1:0]   meas_valid,
  input  logic [TIMEOUT_WIDTH-1:0]  timeout_cycles,
  output logic [NUM_CHANNELS-1:0]   pending,
  output logic                      err_timeout,
  output logic                      err_bad_id
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic [FPROC_ID_WIDTH-1:0] id_q, id_d;
  logic [TIMEOUT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0]  tmo_q, tmo_d;
  logic [NUM_CHANNELS-1:0]   pending_q, pending_d;
  logic [NUM_CHANNELS-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      err_to_q, err_to_d;
  logic                      err_bad_q, err_bad_d;

  logic [NUM_CHANNELS-1:0]   req_oh, wait_oh, consume;
  logic                      id_ok;
  logic                      req_valid, req_meas, req_pend, req_res;
  logic                      wait_valid, wait_meas;

  // One-hot channel decode for the incoming request and for the latched id.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      assign req_oh[gi]    = (fproc_id == FPROC_ID_WIDTH'(gi));
      assign wait_oh[gi]   = (id_q == FPROC_ID_WIDTH'(gi));
      // A channel being consumed this cycle never becomes pending.
      assign pending_d[gi] = consume[gi] ? 1'b0 : (meas_valid[gi] | pending_q[gi]);
      assign result_d[gi]  = (meas_valid[gi] && !consume[gi]) ? meas[gi] : result_q[gi];
    end
  endgenerate

  assign id_ok      = (32'(fproc_id) < NUM_CHANNELS);
  assign req_valid  = |(meas_valid & req_oh);
  assign req_meas   = |(meas & req_oh);
  assign req_pend   = |(pending_q & req_oh);
  assign req_res    = |(result_q & req_oh);
  assign wait_valid = |(meas_valid & wait_oh);
  assign wait_meas  = |(meas & wait_oh);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    err_to_d  = 1'b0;
    err_bad_d = 1'b0;
    consume   = '0;
    case (state_q)
      IDLE: begin
        if (fproc_enable) begin
          id_d = fproc_id;
          if (!id_ok) begin
            state_d   = RESP;
            data_d    = '0;
            err_bad_d = 1'b1;
          end else if (req_valid) begin
            state_d = RESP;
            data_d  = DATA_WIDTH'(req_meas);
            consume = req_oh;
          end else if (req_pend) begin
            state_d = RESP;
            data_d  = DATA_WIDTH'(req_res);
            consume = req_oh;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
            tmo_d   = timeout_cycles;
          end
        end
      end
      WAIT: begin
        if (wait_valid) begin
          state_d = RESP;
          data_d  = DATA_WIDTH'(wait_meas);
          consume = wait_oh;
        end else if (tmo_q != '0 && cnt_q == tmo_q - TIMEOUT_WIDTH'(1)) begin
          state_d  = RESP;
          data_d   = '1;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      pending_q <= '0;
      result_q  <= '0;
      data_q    <= '0;
      err_to_q  <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      pending_q <= pending_d;
      result_q  <= result_d;
      data_q    <= data_d;
      err_to_q  <= err_to_d;
      err_bad_q <= err_bad_d;
    end
  end

  assign fproc_ready = (state_q == RESP);
  assign fproc_data  = data_q;
  assign pending     = pending_q;
  assign err_timeout = err_to_q;
  assign err_bad_id  = err_bad_q;

endmodule
